// File: rtl/serial_shift_datapath.sv
// Parallel-in / serial-out shifter with one holding register ahead of the shift register.
// Latency: word accepted at edge N is shifting (ser_valid=1) after edge N+1 when En=1.
// Backpressure: load_ready drops while the holding register is full; it reopens the cycle after a hold->shift transfer.
//
// Ports:
//   Clk, Reset            clock and asynchronous active-high reset
//   En, shifterEn         global enable and per-bit shift strobe from the timing controller
//   load_valid/load_ready/load_data   parallel word handshake into the holding register
//   ser_out, ser_valid    serial bit and its qualifier (high while a word is in the shift register)
//   bit_idx               bits already shifted from the current word
//   word_done             one-cycle pulse after the last bit of a word has been shifted
//   busy                  a word is shifting or waiting in the holding register
module serial_shift_datapath #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     En,
   input  logic                     shifterEn,
   input  logic                     load_valid,
   input  logic [WIDTH-1:0]         load_data,
   output logic                     load_ready,
   output logic                     ser_out,
   output logic                     ser_valid,
   output logic [$clog2(WIDTH)-1:0] bit_idx,
   output logic                     word_done,
   output logic                     busy
);

   localparam int            IW       = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             done_q, done_d;

   logic             step;
   logic [WIDTH-1:0] shreg_shifted;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shreg_q     <= '0;
         idx_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shreg_q     <= shreg_d;
         idx_q       <= idx_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shreg_d     = shreg_q;
      idx_d       = idx_q;
      done_d      = 1'b0;

      step = En & shifterEn;

      // Move toward the output bit with zero fill, so an emptied word leaves shreg at 0.
      if (MSB_FIRST) shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
      else           shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};

      // Loads ignore En. A load can only land while hold is empty, and a transfer
      // only happens while hold is full, so the two never collide on hold_full.
      if (load_valid && !hold_full_q) begin
         hold_d      = load_data;
         hold_full_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (En && hold_full_q) begin
               shreg_d     = hold_q;
               hold_full_d = 1'b0;
               idx_d       = '0;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            if (step) begin
               if (idx_q == LAST_IDX) begin
                  done_d = 1'b1;
                  idx_d  = '0;
                  if (hold_full_q) begin
                     // Reload on the same edge so the next word follows with no bubble.
                     shreg_d     = hold_q;
                     hold_full_d = 1'b0;
                  end else begin
                     shreg_d = shreg_shifted;
                     state_d = IDLE;
                  end
               end else begin
                  shreg_d = shreg_shifted;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ser_valid  = (state_q == SHIFT);
   assign ser_out    = ser_valid & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
   assign bit_idx    = idx_q;
   assign word_done  = done_q;
   assign load_ready = ~hold_full_q;
   assign busy       = ser_valid | hold_full_q;

endmodule

// File: tb/tb_serial_shift_datapath.sv
module tb_serial_shift_datapath;

   localparam int W   = 8;
   localparam bit MSB = 1'b1;

   logic         Clk = 1'b0;
   logic         Reset = 1'b0;
   logic         En = 1'b0;
   logic         shifterEn = 1'b0;
   logic         load_valid = 1'b0;
   logic [W-1:0] load_data = '0;
   logic         load_ready, ser_out, ser_valid, word_done, busy;
   logic [2:0]   bit_idx;

   int checks = 0;
   int errors = 0;

   // Word-level reference: the word being serialised, how many bits are gone,
   // and a queue holding at most one waiting word.
   int  m_cur = 0;
   int  m_idx = 0;
   bit  m_act = 1'b0;
   bit  m_done = 1'b0;
   int  m_pend[$];

   serial_shift_datapath #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
      .Clk(Clk), .Reset(Reset), .En(En), .shifterEn(shifterEn),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .ser_out(ser_out), .ser_valid(ser_valid), .bit_idx(bit_idx),
      .word_done(word_done), .busy(busy)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_bit();
      int sh;
      if (!m_act) return 0;
      sh = MSB ? (W - 1 - m_idx) : m_idx;
      return (m_cur >> sh) & 1;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".ser_valid"},  32'(ser_valid),  32'(m_act));
      chk({tag, ".ser_out"},    32'(ser_out),    32'(exp_bit()));
      chk({tag, ".bit_idx"},    32'(bit_idx),    32'(m_idx));
      chk({tag, ".word_done"},  32'(word_done),  32'(m_done));
      chk({tag, ".load_ready"}, 32'(load_ready), 32'(m_pend.size() == 0));
      chk({tag, ".busy"},       32'(busy),       32'(m_act || m_pend.size() != 0));
   endtask

   task automatic model_reset();
      m_cur = 0; m_idx = 0; m_act = 1'b0; m_done = 1'b0;
      m_pend.delete();
   endtask

   // Called just after a negedge: drive inputs, advance the model across the
   // rising edge, then compare 1 time unit later.
   task automatic step(input string tag, input bit en, input bit se, input bit lv, input logic [W-1:0] ld);
      bit rdy;
      En = en; shifterEn = se; load_valid = lv; load_data = ld;
      @(posedge Clk);
      rdy = (m_pend.size() == 0);
      m_done = 1'b0;
      if (!m_act) begin
         if (en && m_pend.size() != 0) begin
            m_cur = m_pend.pop_front(); m_act = 1'b1; m_idx = 0;
         end
      end else if (en && se) begin
         if (m_idx == W - 1) begin
            m_done = 1'b1; m_idx = 0;
            if (m_pend.size() != 0) m_cur = m_pend.pop_front();
            else m_act = 1'b0;
         end else begin
            m_idx++;
         end
      end
      if (lv && rdy) m_pend.push_back(int'(ld));
      #1;
      check_all(tag);
      @(negedge Clk);
   endtask

   task automatic async_reset(input string tag);
      Reset = 1'b1;
      model_reset();
      #1;
      check_all({tag, ".async"});
      @(posedge Clk); #1;
      check_all({tag, ".held"});
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   initial begin
      int done_cnt;

      // Reset pulse in the middle of the low phase, before any clock edge.
      #3;
      async_reset("rst");
      step("idle", 1'b1, 1'b1, 1'b0, '0);

      // Single word A5, strobe every 4th cycle.
      step("a5_load", 1'b1, 1'b0, 1'b1, 8'hA5);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step("a5", 1'b1, (i % 4) == 3, 1'b0, '0);
         if (word_done === 1'b1) done_cnt++;
      end
      chk("a5.done_count", 32'(done_cnt), 32'd1);
      chk("a5.ser_valid_end", 32'(ser_valid), 32'd0);

      // Back-to-back F0 then 0F, strobe tied high.
      step("b2b_f0", 1'b1, 1'b1, 1'b1, 8'hF0);
      step("b2b_wait", 1'b1, 1'b1, 1'b1, 8'h0F);
      step("b2b_0f", 1'b1, 1'b1, 1'b1, 8'h0F);
      done_cnt = 0;
      for (int i = 0; i < 18; i++) begin
         step("b2b", 1'b1, 1'b1, 1'b0, '0);
         if (word_done === 1'b1) done_cnt++;
      end
      chk("b2b.done_count", 32'(done_cnt), 32'd2);

      // Backpressure: hold full while shifting is stalled.
      step("bp_11", 1'b1, 1'b0, 1'b1, 8'h11);
      step("bp_xfer", 1'b1, 1'b0, 1'b0, '0);
      step("bp_22", 1'b1, 1'b0, 1'b1, 8'h22);
      for (int i = 0; i < 4; i++) step("bp_33_blocked", 1'b1, 1'b0, 1'b1, 8'h33);
      chk("bp.load_ready", 32'(load_ready), 32'd0);
      for (int i = 0; i < 30; i++) step("bp_drain", 1'b1, 1'b1, (i < 12), 8'h33);

      // En freeze at bit_idx 3.
      step("frz_load", 1'b1, 1'b0, 1'b1, 8'h3C);
      step("frz_xfer", 1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 3; i++) step("frz_pre", 1'b1, 1'b1, 1'b0, '0);
      for (int i = 0; i < 5; i++) step("frz_hold", 1'b0, 1'b1, 1'b0, '0);
      chk("frz.bit_idx", 32'(bit_idx), 32'd3);
      for (int i = 0; i < 8; i++) step("frz_resume", 1'b1, 1'b1, 1'b0, '0);

      // Reset mid-word at bit_idx 5 with the holding register full.
      step("mr_load1", 1'b1, 1'b0, 1'b1, 8'h5A);
      step("mr_xfer", 1'b1, 1'b0, 1'b0, '0);
      step("mr_load2", 1'b1, 1'b0, 1'b1, 8'hC3);
      for (int i = 0; i < 5; i++) step("mr_shift", 1'b1, 1'b1, 1'b0, '0);
      chk("mr.bit_idx", 32'(bit_idx), 32'd5);
      chk("mr.hold_full", 32'(load_ready), 32'd0);
      async_reset("mr");
      step("mr_after", 1'b1, 1'b1, 1'b0, '0);
      step("mr_reload", 1'b1, 1'b0, 1'b1, 8'h81);
      step("mr_restart", 1'b1, 1'b0, 1'b0, '0);
      chk("mr.restart_idx", 32'(bit_idx), 32'd0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step("rnd", $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, W'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_shift_datapath.md
Name: serial_shift_datapath

Overview:
Parallel-in, serial-out shift datapath directly downstream of the shift-timing controller. Consumes the controller's shifterEn strobe, emits one data bit per strobe, and double-buffers parallel words (one holding register plus the active shift register) so back-to-back words shift with no gap in strobes. Reports word completion so upstream logic can sequence further words.

Parameters:
WIDTH, 8, bits per word; legal range 2..16.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset  input  1  asynchronous, active-high reset; one clock domain only.
En  input  1  global enable, same signal that drives the controller; gates shifting and hold-to-shift transfer.
shifterEn  input  1  shift strobe from controller; one bit advances per cycle with En & shifterEn high.
load_valid  input  1  upstream offers load_data this cycle.
load_data  input  WIDTH  parallel word to serialise.
load_ready  output  1  holding register empty; word accepted on edge where load_valid & load_ready.
ser_out  output  1  current serial bit; meaningful only while ser_valid = 1.
ser_valid  output  1  high while a word is in the shift register (state SHIFT).
bit_idx  output  clog2(WIDTH)  number of bits already shifted from the current word.
word_done  output  1  one-cycle pulse, cycle after last bit of a word is shifted.
busy  output  1  ser_valid OR holding register full.

Behaviour:
- Reset asserted (asynchronous): state IDLE, hold_full=0, shift reg=0, bit_idx=0, ser_out=0, ser_valid=0, word_done=0, busy=0, load_ready=1. Reset mid-word discards both the holding word and the shifting word; no word_done is generated.
- All outputs are registered or decoded purely from state/registers; no combinational path from any input to any output.
- Load: on an edge with load_valid & load_ready, hold <- load_data, hold_full <- 1. load_ready = !hold_full (registered view), so one cycle after acceptance load_ready=0. Loads are accepted regardless of En.
- States: IDLE, SHIFT.
- IDLE -> SHIFT: on an edge with En=1 and hold_full=1: shift reg <- hold, hold_full <- 0, bit_idx <- 0. Latency: word accepted at edge N, ser_valid=1 at edge N+1 when En=1. shifterEn is ignored in IDLE.
- SHIFT: ser_out = shift reg[WIDTH-1] when MSB_FIRST=1, else shift reg[0]. On an edge with En & shifterEn: shift reg moves one position toward the output bit (zero fill), bit_idx += 1.
- Last bit (bit_idx = WIDTH-1 and En & shifterEn): word_done=1 next cycle for exactly one cycle. If hold_full=1 at that edge, transfer hold to shift reg at the same edge, bit_idx <- 0, and stay in SHIFT (no bubble). Otherwise go to IDLE, ser_valid <- 0, bit_idx <- 0.
- Simultaneous load and transfer at one edge cannot occur with a full hold register, because load_ready=0 when hold_full=1. At the transfer edge hold_full clears, so load_ready=1 the following cycle.
- En=0: state, shift reg, bit_idx and transfer are frozen; ser_out holds its value; word_done is not generated. Loads still complete.
- bit_idx never exceeds WIDTH-1; no wrap-around beyond the word boundary.
- shifterEn held high continuously: one bit per cycle, WIDTH cycles per word.

Test Plan:
- Reset then idle, WIDTH=8: Reset pulse mid-cycle -> all outputs 0 and load_ready=1 immediately, without waiting for a Clk edge.
- Single word, MSB_FIRST=1: load 8'hA5, En=1, shifterEn pulse every 4 cycles -> ser_out 1,0,1,0,0,1,0,1; word_done pulses once, one cycle after the 8th strobe; ser_valid then falls.
- Back-to-back, shifterEn tied high: load 8'hF0, then 8'h0F while the first word shifts -> 16 consecutive bits 11110000 00001111, ser_valid stays high throughout, word_done pulses at cycles 8 and 16 after the first transfer.
- Backpressure: load 8'h11 then 8'h22 (hold full) with shifterEn=0 -> load_ready=0; a third load_valid with 8'h33 is not accepted until the first word completes.
- En freeze: during a word at bit_idx=3, drop En for 5 cycles with shifterEn=1 -> bit_idx stays 3, ser_out unchanged; shifting resumes when En returns.
- Reset mid-word: assert Reset at bit_idx=5 with hold full -> IDLE, hold empty, no word_done; the next load restarts at bit_idx=0.
